// File: rtl/smc_pkg.sv
// smc_pkg: shared fixed-point constants and saturation helpers for the SMC controller
package smc_pkg;

  localparam int FRAC_W = 10;

  localparam logic signed [31:0] SAT32_MAX = 32'sh7FFF_FFFF;
  localparam logic signed [31:0] SAT32_MIN = 32'sh8000_0000;

  localparam logic signed [31:0] LAMBDA_DEF = 32'sd10240;
  localparam logic signed [31:0] K_GAIN_DEF = 32'sd2048;

  function automatic logic ovf32(input logic signed [63:0] x);
    return (x > 64'(SAT32_MAX)) || (x < 64'(SAT32_MIN));
  endfunction

  function automatic logic signed [31:0] sat32(input logic signed [63:0] x);
    return (x > 64'(SAT32_MAX)) ? SAT32_MAX : (x < 64'(SAT32_MIN)) ? SAT32_MIN : x[31:0];
  endfunction

endpackage

// File: rtl/sliding_surface_law_if.sv
// sliding_surface_law_if: sample strobe/data in, switching term/surface out
interface sliding_surface_law_if;
  logic               sample_valid;
  logic signed [31:0] theta_meas;
  logic signed [31:0] theta_dot_meas;
  logic signed [31:0] model_u;
  logic signed [31:0] model_udot;
  logic               u_valid;
  logic signed [31:0] u_sw;
  logic signed [31:0] s_out;
  logic               sat_flag;

  modport master (
    output sample_valid, theta_meas, theta_dot_meas, model_u, model_udot,
    input  u_valid, u_sw, s_out, sat_flag
  );

  modport slave (
    input  sample_valid, theta_meas, theta_dot_meas, model_u, model_udot,
    output u_valid, u_sw, s_out, sat_flag
  );
endinterface

// File: rtl/sat_addsub32.sv
// sat_addsub32: combinational 32-bit signed add/subtract clamped to the 32-bit range
module sat_addsub32
  import smc_pkg::*;
(
  input  logic signed [31:0] a_i,
  input  logic signed [31:0] b_i,
  input  logic               sub_i,
  output logic signed [31:0] y_o,
  output logic               sat_o
);
  logic signed [32:0] r;

  // 33-bit result; overflow shows as disagreement of the top two bits
  always_comb begin
    r     = sub_i ? (33'(a_i) - 33'(b_i)) : (33'(a_i) + 33'(b_i));
    sat_o = r[32] ^ r[31];
    y_o   = !sat_o ? r[31:0] : r[32] ? SAT32_MIN : SAT32_MAX;
  end
endmodule

// File: rtl/sliding_surface_law.sv
// sliding_surface_law: SMC surface s = LAMBDA*e + edot and switching term u_sw = -K*sat(s);
// SMC_BOUNDARY_LAYER_EN selects the linear boundary-layer law instead of the pure sign law
module sliding_surface_law
  import smc_pkg::*;
#(
  parameter logic signed [31:0] LAMBDA    = LAMBDA_DEF,
  parameter logic signed [31:0] K_GAIN    = K_GAIN_DEF,
  parameter int                 PHI_SHIFT = 10
) (
  input  logic                   clk,
  input  logic                   rst_n,
  sliding_surface_law_if.slave   bus
);
  logic               v1_q, v2_q, v3_q, v4_q;
  logic               f1_q, f2_q, f3_q, f4_q;
  logic signed [31:0] e_q, ed_q, ps_q, ed2_q, s_q, u_q, so_q;

  logic signed [31:0] e_d, ed_d, s_d, ps_d, u_d;
  logic               sat_e, sat_ed, sat_s, sat_p;
  logic signed [63:0] lam64, e64, p_d, p10_d;

  sat_addsub32 u_err (
    .a_i(bus.theta_meas), .b_i(bus.model_u), .sub_i(1'b1), .y_o(e_d), .sat_o(sat_e)
  );

  sat_addsub32 u_derr (
    .a_i(bus.theta_dot_meas), .b_i(bus.model_udot), .sub_i(1'b1), .y_o(ed_d), .sat_o(sat_ed)
  );

  sat_addsub32 u_surf (
    .a_i(ps_q), .b_i(ed2_q), .sub_i(1'b0), .y_o(s_d), .sat_o(sat_s)
  );

  // LAMBDA*e is En20; shifting back by the fraction width returns to En10
  always_comb begin
    lam64 = 64'(LAMBDA);
    e64   = 64'(e_q);
    p_d   = lam64 * e64;
    p10_d = p_d >>> FRAC_W;
    ps_d  = sat32(p10_d);
    sat_p = ovf32(p10_d);
  end

`ifdef SMC_BOUNDARY_LAYER_EN
  logic signed [63:0] k64, s64, kp_d;

  // linear inside |s| < phi, clamped to +/-K_GAIN outside
  always_comb begin
    k64  = 64'(K_GAIN);
    s64  = 64'(s_q);
    kp_d = (k64 * s64) >>> PHI_SHIFT;
    u_d  = (kp_d > k64) ? -K_GAIN : (kp_d < -k64) ? K_GAIN : 32'(-kp_d);
  end
`else
  // pure sign law, no multiplier
  always_comb begin
    u_d = s_q[31] ? K_GAIN : (|s_q) ? -K_GAIN : 32'sd0;
  end
`endif

  // four register ranks: errors, scaled position error, surface, law output
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      {v1_q, v2_q, v3_q, v4_q} <= '0;
      {f1_q, f2_q, f3_q, f4_q} <= '0;
      e_q   <= '0;
      ed_q  <= '0;
      ps_q  <= '0;
      ed2_q <= '0;
      s_q   <= '0;
      u_q   <= '0;
      so_q  <= '0;
    end else begin
      v1_q <= bus.sample_valid;
      v2_q <= v1_q;
      v3_q <= v2_q;
      v4_q <= v3_q;
      if (bus.sample_valid) begin
        e_q  <= e_d;
        ed_q <= ed_d;
        f1_q <= sat_e | sat_ed;
      end
      if (v1_q) begin
        ps_q  <= ps_d;
        ed2_q <= ed_q;
        f2_q  <= f1_q | sat_p;
      end
      if (v2_q) begin
        s_q  <= s_d;
        f3_q <= f2_q | sat_s;
      end
      if (v3_q) begin
        u_q  <= u_d;
        so_q <= s_q;
        f4_q <= f3_q;
      end
    end
  end

  assign bus.u_valid  = v4_q;
  assign bus.u_sw     = u_q;
  assign bus.s_out    = so_q;
  assign bus.sat_flag = f4_q;
endmodule

// File: tb/tb_sliding_surface_law.sv
// tb_sliding_surface_law: randomized scoreboard bench against an arithmetic reference model
module tb_sliding_surface_law;
  localparam longint MAXV = 64'sd2147483647;
  localparam longint MINV = -64'sd2147483648;
  localparam longint LAM  = 10240;
  localparam longint KG   = 2048;
  localparam int     PHI  = 10;

  typedef struct {
    int unsigned        cyc;
    logic signed [31:0] u;
    logic signed [31:0] s;
    logic               f;
  } exp_t;

  logic clk = 0;
  logic rst_n = 1;
  int unsigned cyc = 0;
  int nvec = 0;
  int nerr = 0;
  exp_t q[$];

  sliding_surface_law_if bus();

  sliding_surface_law #(
    .LAMBDA(32'sd10240), .K_GAIN(32'sd2048), .PHI_SHIFT(PHI)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic longint clip(input longint x, inout bit f);
    if (x > MAXV) begin f = 1; return MAXV; end
    if (x < MINV) begin f = 1; return MINV; end
    return x;
  endfunction

  function automatic exp_t model(input longint tm, tdm, mu, mud, input int unsigned c);
    exp_t r;
    bit f = 0;
    longint e, ed, s, u, k;
    e  = clip(tm - mu, f);
    ed = clip(tdm - mud, f);
    s  = clip(clip((LAM * e) >>> 10, f) + ed, f);
`ifdef SMC_BOUNDARY_LAYER_EN
    k = (KG * s) >>> PHI;
    u = (k > KG) ? -KG : (k < -KG) ? KG : -k;
`else
    k = 0;
    u = (s > 0) ? -KG : (s < 0) ? KG : k;
`endif
    r.cyc = c;
    r.u = 32'(u);
    r.s = 32'(s);
    r.f = f;
    return r;
  endfunction

  function automatic logic signed [31:0] rnd();
    int sel = int'($urandom_range(0, 9));
    if (sel < 5) return 32'(int'($urandom_range(0, 8000)) - 4000);
    if (sel == 5) return 32'sh7FFF_FFFF;
    if (sel == 6) return 32'sh8000_0000;
    if (sel == 7) return 32'(int'($urandom_range(0, 200)) - 100);
    return $urandom;
  endfunction

  task automatic send(input logic signed [31:0] tm, tdm, mu, mud);
    @(posedge clk);
    #2;
    bus.sample_valid   = 1;
    bus.theta_meas     = tm;
    bus.theta_dot_meas = tdm;
    bus.model_u        = mu;
    bus.model_udot     = mud;
    q.push_back(model(longint'(tm), longint'(tdm), longint'(mu), longint'(mud), cyc + 4));
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
      bus.sample_valid   = 0;
      bus.theta_meas     = $urandom;
      bus.theta_dot_meas = $urandom;
      bus.model_u        = $urandom;
      bus.model_udot     = $urandom;
    end
  endtask

  task automatic chk_zero(input string name, input logic signed [31:0] act);
    nvec++;
    if (act !== 0) begin
      nerr++;
      $display("FAIL %s: got %0d, expected 0", name, act);
    end
  endtask

  task automatic chk_outs_zero();
    chk_zero("u_valid", 32'(bus.u_valid));
    chk_zero("u_sw", bus.u_sw);
    chk_zero("s_out", bus.s_out);
    chk_zero("sat_flag", 32'(bus.sat_flag));
  endtask

  // monitor: every u_valid pops the oldest expectation; overdue ones count as missing
  always @(negedge clk) begin
    exp_t x;
    while (q.size() != 0 && q[0].cyc < cyc) begin
      x = q.pop_front();
      nvec++;
      nerr++;
      $display("FAIL missing u_valid at cycle %0d", x.cyc);
    end
    if (bus.u_valid === 1'b1) begin
      nvec++;
      if (q.size() == 0) begin
        nerr++;
        $display("FAIL unexpected u_valid at cycle %0d: got u_sw=%0d s=%0d, expected none", cyc, bus.u_sw, bus.s_out);
      end else begin
        x = q.pop_front();
        if (x.cyc != cyc || bus.u_sw !== x.u || bus.s_out !== x.s || bus.sat_flag !== x.f) begin
          nerr++;
          $display("FAIL result: got cyc=%0d u_sw=%0d s=%0d flag=%0b, expected cyc=%0d u_sw=%0d s=%0d flag=%0b",
                   cyc, bus.u_sw, bus.s_out, bus.sat_flag, x.cyc, x.u, x.s, x.f);
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    bus.sample_valid = 0;
    bus.theta_meas = 0;
    bus.theta_dot_meas = 0;
    bus.model_u = 0;
    bus.model_udot = 0;
    #1 rst_n = 0;
    #1 chk_outs_zero();
    repeat (3) @(posedge clk);
    #2 rst_n = 1;
    idle(2);
    send(1024, 0, 0, 0);
    idle(1);
    send(51, 0, 0, 0);
    send(-1024, 0, 0, 0);
    send(5000, 5000, 5000, 5000);
    send(32'sh7FFF_FFFF, 0, 32'sh8000_0000, 0);
    idle(2);
    send(1024, 0, 0, 0);
    send(-1024, 0, 0, 0);
    send(0, 0, 0, 0);
    idle(6);
    send(1024, 0, 0, 0);
    send(-1024, 0, 0, 0);
    idle(1);
    @(posedge clk);
    #2 rst_n = 0;
    #1 chk_outs_zero();
    q.delete();
    repeat (2) @(posedge clk);
    #2 rst_n = 1;
    idle(8);
    send(2048, 0, 0, 0);
    idle(5);
    repeat (400) begin
      if ($urandom_range(0, 9) < 7) send(rnd(), rnd(), rnd(), rnd());
      else idle(1);
    end
    idle(8);
    if (q.size() != 0) begin
      nvec++;
      nerr++;
      $display("FAIL drain: %0d results outstanding, expected 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
